// File: rtl/adam_rst_seq_pkg.sv
// adam_rst_seq_pkg
// Shared types for the board-level reset sequencer:
//   state_e : sequencer FSM states
//   cause_e : encoding of rst_cause_o (cause of the last reset)
//   max3    : helper used to size the shared phase counter
package adam_rst_seq_pkg;

  typedef enum logic [2:0] {
    ST_ASSERT   = 3'd0,
    ST_DEBOUNCE = 3'd1,
    ST_HOLD     = 3'd2,
    ST_RUN      = 3'd3,
    ST_SOFT     = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0,
    CAUSE_EXT  = 2'd1,
    CAUSE_SOFT = 2'd2,
    CAUSE_LOCK = 2'd3
  } cause_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/adam_sync.sv
// adam_sync
// N-flop synchronizer with asynchronous active-low clear.
//   clk   : destination clock
//   clr_n : asynchronous clear, active-low (forces the whole chain to 0)
//   d     : asynchronous input
//   q     : synchronized output (last stage of the chain)
module adam_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic clr_n,
  input  logic d,
  output logic q
);

  logic [N-1:0] chain;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[N-2:0], d};
    end
  end

  assign q = chain[N-1];

endmodule

// File: rtl/adam_rst_seq.sv
// adam_rst_seq
// Board-level reset sequencer. Asserts rst_o asynchronously when the board
// button goes low; releases it only after the button release has been
// synchronized, debounced for DEBOUNCE_CYCLES and stretched by HOLD_CYCLES.
// A soft-reset request in RUN produces a SOFT_PULSE_CYCLES phase followed
// by the normal HOLD phase. rst_cause_o reports why the last reset happened.
//
// Ports:
//   clk_i          : system clock
//   rst_ni         : board reset button, asynchronous, active-low
//   soft_rst_req_i : synchronous soft-reset request, honoured in RUN only
//   lock_i         : PLL locked, asynchronous (only with ADAM_RST_SEQ_LOCK_EN)
//   rst_o          : registered active-high reset for the downstream core
//   ready_o        : registered, high only in RUN
//   rst_cause_o    : 0=none, 1=EXT, 2=SOFT, 3=LOCK
//   state_o        : current FSM state (debug visibility)
//
// Optional feature macro: ADAM_RST_SEQ_LOCK_EN. When defined, lock_i gates
// the HOLD phase and losing lock in RUN re-enters HOLD with cause LOCK.
//
// Handshakes: this block has no valid/ready interfaces; soft_rst_req_i is a
// level sampled on each clk_i edge while in RUN, never queued elsewhere.
module adam_rst_seq
  import adam_rst_seq_pkg::*;
#(
  parameter int SYNC_STAGES       = 2,
  parameter int DEBOUNCE_CYCLES   = 1000,
  parameter int HOLD_CYCLES       = 16,
  parameter int SOFT_PULSE_CYCLES = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       soft_rst_req_i,
`ifdef ADAM_RST_SEQ_LOCK_EN
  input  logic       lock_i,
`endif
  output logic       rst_o,
  output logic       ready_o,
  output logic [1:0] rst_cause_o,
  output state_e     state_o
);

  localparam int CNT_W = $clog2(max3(DEBOUNCE_CYCLES, HOLD_CYCLES, SOFT_PULSE_CYCLES) + 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SOFT_LAST = CNT_W'(SOFT_PULSE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  cause_e           cause_q, cause_d;
  logic             rst_q, rst_d;
  logic             ready_q, ready_d;
  logic             sync_q;
  logic             lock_ok;

  // Release synchronizer: the chain fills with ones after rst_ni rises and
  // is cleared asynchronously by any low glitch on rst_ni.
  adam_sync #(.N(SYNC_STAGES)) u_rst_sync (
    .clk   (clk_i),
    .clr_n (rst_ni),
    .d     (1'b1),
    .q     (sync_q)
  );

`ifdef ADAM_RST_SEQ_LOCK_EN
  logic lock_q;

  adam_sync #(.N(SYNC_STAGES)) u_lock_sync (
    .clk   (clk_i),
    .clr_n (rst_ni),
    .d     (lock_i),
    .q     (lock_q)
  );

  assign lock_ok = lock_q;
`else
  assign lock_ok = 1'b1;
`endif

  // Counters saturate instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // State register (plus phase counter and registered outputs).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_ASSERT;
      cnt_q   <= '0;
      cause_q <= CAUSE_EXT;
      rst_q   <= 1'b1;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_ASSERT: begin
        cnt_d = '0;
        if (sync_q) state_d = ST_DEBOUNCE;
      end
      ST_DEBOUNCE: begin
        if (cnt_q == DEB_LAST) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      ST_HOLD: begin
        // Without lock the counter freezes at its current value.
        if (lock_ok) begin
          if (cnt_q == HOLD_LAST) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = sat_inc(cnt_q);
          end
        end
      end
      ST_RUN: begin
        cnt_d = '0;
        if (!lock_ok) begin
          state_d = ST_HOLD;
        end else if (soft_rst_req_i) begin
          state_d = ST_SOFT;
        end
      end
      ST_SOFT: begin
        if (cnt_q == SOFT_LAST) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      default: begin
        state_d = ST_ASSERT;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic: outputs are decoded from the next state and registered,
  // so rst_o/ready_o change on the same edge as the state and never glitch.
  always_comb begin
    rst_d   = (state_d != ST_RUN);
    ready_d = (state_d == ST_RUN);
    cause_d = cause_q;
    if (state_q == ST_RUN && state_d == ST_SOFT) cause_d = CAUSE_SOFT;
    if (state_q == ST_RUN && state_d == ST_HOLD) cause_d = CAUSE_LOCK;
  end

  assign rst_o       = rst_q;
  assign ready_o     = ready_q;
  assign rst_cause_o = cause_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_adam_rst_seq.sv
// tb_adam_rst_seq
// Directed bench for adam_rst_seq with default parameters. Edge numbers in
// the steps count rising clk_i edges since the latest rst_ni release.
module tb_adam_rst_seq;
  import adam_rst_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       soft_req;
  logic       rst;
  logic       ready;
  logic [1:0] cause;
  state_e     state;

  int n_checks = 0;
  int n_errors = 0;
  int edge_n   = 0;

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  adam_rst_seq dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .soft_rst_req_i (soft_req),
    .rst_o          (rst),
    .ready_o        (ready),
    .rst_cause_o    (cause),
    .state_o        (state)
  );

  // Advance to just after rising edge number e, then settle 1ns.
  task automatic run_to(input int e);
    while (edge_n < e) begin
      @(posedge clk);
      edge_n++;
    end
    #1;
  endtask

  // Release rst_ni on a falling edge; the next rising edge is edge 1.
  task automatic release_rst();
    @(negedge clk);
    rst_n  = 1'b1;
    edge_n = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    soft_req = 1'b0;

    // Reset state while rst_ni is low
    repeat (5) @(posedge clk);
    #1;
    check("reset_rst",   32'(rst),   32'd1);
    check("reset_ready", 32'(ready), 32'd0);
    check("reset_cause", 32'(cause), 32'd1);
    check("reset_state", 32'(state), 32'(ST_ASSERT));

    // Clean release: rst_o falls after edge 1019
    release_rst();
    run_to(2);
    check("rel_e2_state",    32'(state), 32'(ST_ASSERT));
    run_to(3);
    check("rel_e3_state",    32'(state), 32'(ST_DEBOUNCE));
    run_to(1002);
    check("rel_e1002_state", 32'(state), 32'(ST_DEBOUNCE));
    run_to(1003);
    check("rel_e1003_state", 32'(state), 32'(ST_HOLD));
    run_to(1018);
    check("rel_e1018_rst",   32'(rst),   32'd1);
    check("rel_e1018_ready", 32'(ready), 32'd0);
    run_to(1019);
    check("rel_e1019_rst",   32'(rst),   32'd0);
    check("rel_e1019_ready", 32'(ready), 32'd1);
    check("rel_e1019_cause", 32'(cause), 32'd1);

    // Soft pulse sampled at edge k=1025
    run_to(1024);
    soft_req = 1'b1;
    run_to(1025);
    soft_req = 1'b0;
    check("soft_k_rst",      32'(rst),   32'd1);
    check("soft_k_ready",    32'(ready), 32'd0);
    check("soft_k_cause",    32'(cause), 32'd2);
    run_to(1032);
    check("soft_k7_state",   32'(state), 32'(ST_SOFT));
    run_to(1033);
    check("soft_k8_state",   32'(state), 32'(ST_HOLD));
    run_to(1048);
    check("soft_k23_rst",    32'(rst),   32'd1);
    check("soft_k23_ready",  32'(ready), 32'd0);
    run_to(1049);
    check("soft_k24_rst",    32'(rst),   32'd0);
    check("soft_k24_ready",  32'(ready), 32'd1);
    check("soft_k24_cause",  32'(cause), 32'd2);

    // Async assertion mid-cycle in RUN, checked before the next edge
    run_to(1060);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst",   32'(rst),   32'd1);
    check("async_ready", 32'(ready), 32'd0);
    check("async_cause", 32'(cause), 32'd1);
    check("async_state", 32'(state), 32'(ST_ASSERT));

    // Release, then a one-cycle low glitch at edge 500 restarts the count
    release_rst();
    run_to(500);
    check("glitch_pre_state", 32'(state), 32'(ST_DEBOUNCE));
    rst_n = 1'b0;
    #1;
    check("glitch_rst",   32'(rst),   32'd1);
    check("glitch_state", 32'(state), 32'(ST_ASSERT));
    @(posedge clk);
    release_rst();

    // Soft request during HOLD is ignored
    run_to(1005);
    check("hold_state", 32'(state), 32'(ST_HOLD));
    soft_req = 1'b1;
    run_to(1010);
    check("hold_soft_state", 32'(state), 32'(ST_HOLD));
    check("hold_soft_cause", 32'(cause), 32'd1);
    soft_req = 1'b0;
    run_to(1018);
    check("re_e1018_rst",   32'(rst),   32'd1);
    run_to(1019);
    check("re_e1019_rst",   32'(rst),   32'd0);
    check("re_e1019_ready", 32'(ready), 32'd1);
    check("re_e1019_cause", 32'(cause), 32'd1);

    // Held request re-triggers on each entry to RUN
    run_to(1020);
    soft_req = 1'b1;
    run_to(1021);
    check("held_k_rst",    32'(rst),   32'd1);
    check("held_k_cause",  32'(cause), 32'd2);
    run_to(1045);
    check("held_run_ready", 32'(ready), 32'd1);
    check("held_run_rst",   32'(rst),   32'd0);
    run_to(1046);
    check("held_retrig_rst",   32'(rst),   32'd1);
    check("held_retrig_state", 32'(state), 32'(ST_SOFT));
    soft_req = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
